// File: rtl/router_rr_packet_arbiter.sv
// Packet-aware round-robin arbiter: grants one input queue and holds it from head to tail flit.
// The pointer gives the last winner lowest priority when the next packet is arbitrated.
module router_rr_packet_arbiter #(
  parameter int unsigned REN   = 5,
  parameter int unsigned REN_B = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REN-1:0]   req,
  input  logic [REN-1:0]   head,
  input  logic [REN-1:0]   tail,
  input  logic             out_ready,
  output logic [REN-1:0]   grant,
  output logic [REN_B-1:0] sel,
  output logic             out_valid,
  output logic [REN-1:0]   shift,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic             err_orphan
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [REN-1:0]     grant_q, grant_d;
  logic [REN_B-1:0]   sel_q, sel_d;
  logic [REN_B-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [REN-1:0]     cand;
  logic [REN_B-1:0]   pick;
  logic               found;
  logic               xfer;
  int unsigned        idx;

  assign cand = req & head;

  // Scan from ptr upward, wrapping at REN; the first candidate hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < REN; k++) begin
      idx = (32'(ptr_q) + k) % REN;
      if (!found && cand[idx[REN_B-1:0]]) begin
        found = 1'b1;
        pick  = idx[REN_B-1:0];
      end
    end
  end

  assign busy       = (state_q == LOCK);
  assign out_valid  = busy & req[sel_q];
  assign xfer       = out_valid & out_ready;
  assign shift      = xfer ? grant_q : '0;
  assign grant      = grant_q;
  assign sel        = sel_q;
  assign pkt_count  = cnt_q;
  assign err_orphan = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|(req & ~head)) err_d = 1'b1;
        if (found) begin
          grant_d = REN'(1) << pick;
          sel_d   = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer && tail[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (32'(sel_q) == REN - 1) ? '0 : sel_q + REN_B'(1);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_router_rr_packet_arbiter.sv
// Directed bench for router_rr_packet_arbiter: per-cycle vector table plus hand-written
// sequences for reset, stalls and counter wrap (a narrow-counter instance shares the stimulus).
module tb_router_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0, head = '0, tail = '0;
  logic        out_ready = 1'b0;
  logic [4:0]  grant, shift;
  logic [2:0]  sel;
  logic        out_valid, busy, err_orphan;
  logic [15:0] pkt_count;

  logic [4:0]  grant_s, shift_s;
  logic [2:0]  sel_s;
  logic        out_valid_s, busy_s, err_orphan_s;
  logic [2:0]  pkt_count_s;

  int n_vec = 0;
  int n_bad = 0;

  router_rr_packet_arbiter #(.REN(5), .REN_B(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .head(head), .tail(tail), .out_ready(out_ready),
    .grant(grant), .sel(sel), .out_valid(out_valid), .shift(shift), .busy(busy),
    .pkt_count(pkt_count), .err_orphan(err_orphan)
  );

  router_rr_packet_arbiter #(.REN(5), .REN_B(3), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .req(req), .head(head), .tail(tail), .out_ready(out_ready),
    .grant(grant_s), .sel(sel_s), .out_valid(out_valid_s), .shift(shift_s), .busy(busy_s),
    .pkt_count(pkt_count_s), .err_orphan(err_orphan_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  req, head, tail;
    logic        rdy;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        ov;
    logic [4:0]  shift;
    logic        busy;
    logic [15:0] cnt;
    logic        err;
  } tv_t;

  tv_t tbl[$];

  function automatic tv_t mk(logic [4:0] q, logic [4:0] h, logic [4:0] t, logic r,
                             logic [4:0] g, logic [2:0] s, logic ov, logic [4:0] sh,
                             logic b, logic [15:0] c, logic e);
    tv_t v;
    v.req = q; v.head = h; v.tail = t; v.rdy = r;
    v.grant = g; v.sel = s; v.ov = ov; v.shift = sh; v.busy = b; v.cnt = c; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [4:0] q, input logic [4:0] h, input logic [4:0] t,
                       input logic r);
    @(negedge clk);
    req = q; head = h; tail = t; out_ready = r;
    #1;
  endtask

  bit rdy_pat[6] = '{1, 1, 0, 0, 1, 1};
  int pulses, stall, early;

  initial begin
    // round robin over five single-flit packets, then a wormhole hold on port 0, then an orphan
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,0,0,5'h00,0, 0,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h01,0,1,5'h01,1, 0,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,0,0,5'h00,0, 1,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h02,1,1,5'h02,1, 1,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,1,0,5'h00,0, 2,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h04,2,1,5'h04,1, 2,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,2,0,5'h00,0, 3,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h08,3,1,5'h08,1, 3,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,3,0,5'h00,0, 4,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h10,4,1,5'h10,1, 4,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h00,4,0,5'h00,0, 5,0));
    tbl.push_back(mk(5'h1f,5'h1f,5'h1f,1, 5'h01,0,1,5'h01,1, 5,0));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h00,0,0,5'h00,0, 6,0));
    tbl.push_back(mk(5'h01,5'h01,5'h00,1, 5'h00,0,0,5'h00,0, 6,0));
    tbl.push_back(mk(5'h01,5'h01,5'h00,1, 5'h01,0,1,5'h01,1, 6,0));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h01,0,0,5'h00,1, 6,0));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h01,0,0,5'h00,1, 6,0));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h01,0,0,5'h00,1, 6,0));
    tbl.push_back(mk(5'h01,5'h00,5'h00,1, 5'h01,0,1,5'h01,1, 6,0));
    tbl.push_back(mk(5'h01,5'h00,5'h01,1, 5'h01,0,1,5'h01,1, 6,0));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h00,0,0,5'h00,0, 7,0));
    tbl.push_back(mk(5'h02,5'h00,5'h00,1, 5'h00,0,0,5'h00,0, 7,0));
    tbl.push_back(mk(5'h02,5'h00,5'h00,1, 5'h00,0,0,5'h00,0, 7,1));
    tbl.push_back(mk(5'h02,5'h00,5'h00,1, 5'h00,0,0,5'h00,0, 7,1));
    tbl.push_back(mk(5'h02,5'h02,5'h02,1, 5'h00,0,0,5'h00,0, 7,1));
    tbl.push_back(mk(5'h02,5'h02,5'h02,1, 5'h02,1,1,5'h02,1, 7,1));
    tbl.push_back(mk(5'h00,5'h00,5'h00,1, 5'h00,1,0,5'h00,0, 8,1));

    // reset state
    #1;
    chk("rst_grant", grant, 5'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_shift", shift, 5'h00);
    chk("rst_cnt", pkt_count, 16'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].head, tbl[i].tail, tbl[i].rdy);
      chk($sformatf("v%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("v%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("v%0d_shift", i), shift, tbl[i].shift);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_cnt", i), pkt_count, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err_orphan, tbl[i].err);
    end

    // 4-flit packet on port 1 with a 2-cycle stall while port 3 waits with a head
    drive(5'h02, 5'h02, 5'h00, 1);
    chk("p1_idle_grant", grant, 5'h00);
    pulses = 0; stall = 0; early = 0;
    for (int k = 0; k < 6; k++) begin
      drive(5'h0a, (pulses == 0 ? 5'h02 : 5'h00) | 5'h08, (pulses == 3 ? 5'h02 : 5'h00),
            rdy_pat[k]);
      if (shift != 5'h00 && !rdy_pat[k]) stall++;
      if (shift[3] || grant[3]) early++;
      if (shift == 5'h02) pulses++;
    end
    chk("p1_pulses", pulses, 4);
    chk("p1_stall_shift", stall, 0);
    chk("p3_early", early, 0);
    drive(5'h08, 5'h08, 5'h00, 1);
    chk("p3_bubble_grant", grant, 5'h00);
    chk("p3_bubble_busy", busy, 1'b0);
    drive(5'h08, 5'h08, 5'h08, 1);
    chk("p3_grant", grant, 5'h08);
    chk("p3_shift", shift, 5'h08);
    drive(5'h00, 5'h00, 5'h00, 1);
    chk("p3_cnt", pkt_count, 16'd10);

    // async reset while locked on port 2
    drive(5'h04, 5'h04, 5'h00, 0);
    chk("r_idle_grant", grant, 5'h00);
    drive(5'h04, 5'h04, 5'h00, 0);
    chk("r_lock_grant", grant, 5'h04);
    chk("r_lock_sel", sel, 3'd2);
    chk("r_lock_shift", shift, 5'h00);
    #2 rst = 1'b1;
    #1;
    chk("r_grant", grant, 5'h00);
    chk("r_sel", sel, 3'd0);
    chk("r_busy", busy, 1'b0);
    chk("r_valid", out_valid, 1'b0);
    chk("r_shift", shift, 5'h00);
    chk("r_cnt", pkt_count, 16'd0);
    chk("r_err", err_orphan, 1'b0);
    @(negedge clk);
    rst = 1'b0; req = 5'h05; head = 5'h05; tail = 5'h05; out_ready = 1'b1;
    #1;
    chk("r_post_idle", grant, 5'h00);
    drive(5'h05, 5'h05, 5'h05, 1);
    chk("r_ptr0_grant", grant, 5'h01);
    chk("r_ptr0_shift", shift, 5'h01);
    drive(5'h04, 5'h04, 5'h04, 1);
    chk("r_bubble", grant, 5'h00);
    drive(5'h04, 5'h04, 5'h04, 1);
    chk("r_p2_grant", grant, 5'h04);
    chk("r_p2_sel", sel, 3'd2);
    drive(5'h00, 5'h00, 5'h00, 1);
    chk("r_cnt2", pkt_count, 16'd2);

    // counter wrap on the 3-bit instance: 7 packets then 2 more
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int p = 0; p < 7; p++) begin
      drive(5'h01, 5'h01, 5'h01, 1);
      drive(5'h01, 5'h01, 5'h01, 1);
    end
    drive(5'h00, 5'h00, 5'h00, 1);
    chk("w_small_max", pkt_count_s, 3'd7);
    chk("w_big_7", pkt_count, 16'd7);
    for (int p = 0; p < 2; p++) begin
      drive(5'h01, 5'h01, 5'h01, 1);
      drive(5'h01, 5'h01, 5'h01, 1);
    end
    drive(5'h00, 5'h00, 5'h00, 1);
    chk("w_small_wrap", pkt_count_s, 3'd1);
    chk("w_big_9", pkt_count, 16'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
